// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: the default operand width,
// the controller state encoding and the iteration-counter sizing helper.
package div_pkg;

   localparam int DIV_N = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_t;

   // Bits needed to count 0..n-1 iterations (never less than one bit).
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/div_seq_if.sv
// Request/result bundle of the sequential divider.
// Handshake: the requester raises start for one cycle with signed_op/A/B;
// the divider accepts it only while in IDLE. Results are valid in the single
// cycle where done is high and stay stable until the next accepted start.
// state mirrors the controller state for observation.
interface div_seq_if
   import div_pkg::*;
#(
   parameter int N = DIV_N
) ();

   logic         start;
   logic         signed_op;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] Q;
   logic [N-1:0] R;
   logic         DZ;
   div_state_t   state;

   modport master (
      output start, signed_op, A, B,
      input  busy, done, Q, R, DZ, state
   );

   modport slave (
      input  start, signed_op, A, B,
      output busy, done, Q, R, DZ, state
   );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor magnitude, and keep the difference
// only when no borrow occurs.
module div_step #(
   parameter int N = 32
) (
   input  logic [N-1:0] p,
   input  logic         a_msb,
   input  logic [N-1:0] b,
   output logic [N-1:0] p_next,
   output logic         q_bit
);

   logic [N:0]   shifted;
   logic         borrow;
   logic [N-1:0] trial;

   assign shifted = {p, a_msb};
   // Borrow of the N+1-bit trial subtraction.
   assign borrow  = (shifted < {1'b0, b});
   // Only the low N bits of the difference are kept; the top bit is zero
   // whenever the difference is accepted, so it is not needed.
   assign trial   = shifted[N-1:0] - b;
   assign p_next  = borrow ? shifted[N-1:0] : trial;
   assign q_bit   = ~borrow;

endmodule

// File: rtl/div_seq.sv
// Sequential restoring divider, signed or unsigned, N iterations per result.
// Optional macro DIV_ZERO_DETECT_EN: a zero divisor finishes in one cycle
// with DZ=1, Q=all ones, R=A. Without it DZ stays 0 and a zero divisor runs
// through the normal datapath.
module div_seq
   import div_pkg::*;
#(
   parameter int N = DIV_N
) (
   input logic      clk,
   input logic      rst,
   div_seq_if.slave bus
);

`ifdef DIV_ZERO_DETECT_EN
   localparam bit ZERO_DETECT = 1'b1;
`else
   localparam bit ZERO_DETECT = 1'b0;
`endif

   localparam int CW = cnt_width(N);

   div_state_t   state;
   logic [CW-1:0] cnt;
   logic [N-1:0] p;          // partial remainder
   logic [N-1:0] d;          // dividend magnitude, becomes the quotient
   logic [N-1:0] b_mag;
   logic         neg_q;
   logic         neg_r;
   logic         busy_r;
   logic         done_r;
   logic [N-1:0] q_r;
   logic [N-1:0] r_r;
   logic         dz_r;

   logic [N-1:0] a_in_mag;
   logic [N-1:0] b_in_mag;
   logic [N-1:0] p_next;
   logic         q_bit;

   // Operand magnitudes at the request; negation wraps modulo 2^N.
   assign a_in_mag = (bus.signed_op && bus.A[N-1]) ? -bus.A : bus.A;
   assign b_in_mag = (bus.signed_op && bus.B[N-1]) ? -bus.B : bus.B;

   div_step #(.N(N)) u_step (
      .p      (p),
      .a_msb  (d[N-1]),
      .b      (b_mag),
      .p_next (p_next),
      .q_bit  (q_bit)
   );

   // Controller and datapath: accept, iterate N times, fix signs, pulse done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         p      <= '0;
         d      <= '0;
         b_mag  <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         busy_r <= 1'b0;
         done_r <= 1'b0;
         q_r    <= '0;
         r_r    <= '0;
         dz_r   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done_r <= 1'b0;
               if (bus.start) begin
                  if (ZERO_DETECT && (bus.B == '0)) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                     dz_r   <= 1'b1;
                     q_r    <= '1;
                     r_r    <= bus.A;
                  end else begin
                     state  <= CALC;
                     busy_r <= 1'b1;
                     cnt    <= '0;
                     p      <= '0;
                     d      <= a_in_mag;
                     b_mag  <= b_in_mag;
                     neg_q  <= bus.signed_op & (bus.A[N-1] ^ bus.B[N-1]);
                     neg_r  <= bus.signed_op & bus.A[N-1];
                  end
               end
            end
            CALC: begin
               p   <= p_next;
               d   <= {d[N-2:0], q_bit};
               cnt <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state <= FIX;
               end
            end
            FIX: begin
               q_r    <= neg_q ? -d : d;
               r_r    <= neg_r ? -p : p;
               dz_r   <= 1'b0;
               busy_r <= 1'b0;
               done_r <= 1'b1;
               state  <= DONE;
            end
            DONE: begin
               done_r <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.Q     = q_r;
   assign bus.R     = r_r;
   assign bus.DZ    = dz_r;
   assign bus.state = state;

endmodule

// File: tb/tb_div_seq.sv
// Bench for div_seq: scenario tasks push expected results at request time and
// pop them when done is seen. Define DIV_ZERO_DETECT_EN to match a DUT built
// with zero-divisor detection.
module tb_div_seq;
   import div_pkg::*;

   localparam int N     = 32;
   localparam int LIMIT = 200;
`ifdef DIV_ZERO_DETECT_EN
   localparam bit DZ_EN = 1'b1;
`else
   localparam bit DZ_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   logic [2*N:0] exp_q[$];   // {dz, q, r}

   div_seq_if #(.N(N)) bus ();

   div_seq #(.N(N)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Clock
   always #5 clk = ~clk;

   // Watchdog
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // Reference model: divide on magnitudes, apply signs afterwards.
   function automatic logic [2*N:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic sop);
      logic [N-1:0] ma, mb, qm, rm, q, r;
      logic sa, sb;
      sa = sop & a[N-1];
      sb = sop & b[N-1];
      ma = sa ? -a : a;
      mb = sb ? -b : b;
      if (b == '0) begin
         if (DZ_EN) return {1'b1, {N{1'b1}}, a};
         return {1'b0, (sa ? N'(1) : {N{1'b1}}), a};
      end
      qm = ma / mb;
      rm = ma % mb;
      q  = (sa ^ sb) ? -qm : qm;
      r  = sa ? -rm : rm;
      return {1'b0, q, r};
   endfunction

   function automatic int exp_lat(input logic [N-1:0] b);
      return (DZ_EN && (b == '0)) ? 1 : N + 2;
   endfunction

   // Driver: start high for one cycle (cycle 0); returns in cycle 1.
   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic sop);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.A         = a;
      bus.B         = b;
      bus.signed_op = sop;
      exp_q.push_back(model(a, b, sop));
      @(negedge clk);
      bus.start     = 1'b0;
      bus.A         = $urandom();
      bus.B         = $urandom();
      bus.signed_op = 1'($urandom_range(0, 1));
   endtask

   // Waits (bounded) for done; cyc is the cycle index relative to the start cycle.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < LIMIT) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.start = 1'b1;          // reset must win over start
      bus.A = 32'h1234;
      bus.B = '0;
      bus.signed_op = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.Q !== '0) begin failures++; $display("FAIL reset_q got=%h exp=0", bus.Q); end
      checks++; if (bus.R !== '0) begin failures++; $display("FAIL reset_r got=%h exp=0", bus.R); end
      checks++; if (bus.DZ !== 1'b0) begin failures++; $display("FAIL reset_dz got=%b exp=0", bus.DZ); end
      checks++; if (bus.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", bus.state, IDLE); end
      bus.start = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_unsigned();
      logic [2*N:0] e;
      int cyc;
      issue(32'd100, 32'd7, 1'b0);
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL unsigned_busy got=%b exp=1", bus.busy); end
      wait_done(cyc);
      e = exp_q.pop_front();
      checks++; if (cyc != 34) begin failures++; $display("FAIL unsigned_latency got=%0d exp=34", cyc); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL unsigned_busy_done got=%b exp=0", bus.busy); end
      checks++; if (bus.Q !== e[2*N-1:N]) begin failures++; $display("FAIL unsigned_q got=%h exp=%h", bus.Q, e[2*N-1:N]); end
      checks++; if (bus.R !== e[N-1:0]) begin failures++; $display("FAIL unsigned_r got=%h exp=%h", bus.R, e[N-1:0]); end
      checks++; if (bus.DZ !== e[2*N]) begin failures++; $display("FAIL unsigned_dz got=%b exp=%b", bus.DZ, e[2*N]); end
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL unsigned_done_pulse got=%b exp=0", bus.done); end
   endtask

   task automatic test_signed();
      logic [N-1:0] ta [0:5];
      logic [N-1:0] tbv [0:5];
      logic         ts [0:5];
      logic [2*N:0] e;
      int cyc;
      ta  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FF9C, 32'hFFFF_FFF9};
      tbv = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'd7, 32'd2};
      ts  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         issue(ta[i], tbv[i], ts[i]);
         wait_done(cyc);
         e = exp_q.pop_front();
         checks++; if (cyc != N + 2) begin failures++; $display("FAIL signed%0d_latency got=%0d exp=%0d", i, cyc, N + 2); end
         checks++; if (bus.Q !== e[2*N-1:N]) begin failures++; $display("FAIL signed%0d_q got=%h exp=%h", i, bus.Q, e[2*N-1:N]); end
         checks++; if (bus.R !== e[N-1:0]) begin failures++; $display("FAIL signed%0d_r got=%h exp=%h", i, bus.R, e[N-1:0]); end
      end
   endtask

   task automatic test_div_zero();
      logic [2*N:0] e;
      int cyc;
      issue(32'h1234, 32'd0, 1'b0);
      checks++; if (bus.busy !== !DZ_EN) begin failures++; $display("FAIL dz_busy got=%b exp=%b", bus.busy, !DZ_EN); end
      wait_done(cyc);
      e = exp_q.pop_front();
      checks++; if (cyc != exp_lat(32'd0)) begin failures++; $display("FAIL dz_latency got=%0d exp=%0d", cyc, exp_lat(32'd0)); end
      checks++; if (bus.Q !== e[2*N-1:N]) begin failures++; $display("FAIL dz_q got=%h exp=%h", bus.Q, e[2*N-1:N]); end
      checks++; if (bus.R !== e[N-1:0]) begin failures++; $display("FAIL dz_r got=%h exp=%h", bus.R, e[N-1:0]); end
      checks++; if (bus.DZ !== e[2*N]) begin failures++; $display("FAIL dz_flag got=%b exp=%b", bus.DZ, e[2*N]); end
   endtask

   task automatic test_ignore_start();
      logic [2*N:0] e;
      int cyc;
      int stray;
      issue(32'd1000, 32'd3, 1'b0);
      cyc = 1;
      while (bus.done !== 1'b1 && cyc < LIMIT) begin
         bus.start = (cyc == 5 || cyc == 20);
         bus.A     = $urandom();
         bus.B     = 32'($urandom_range(0, 9));
         @(negedge clk);
         cyc++;
      end
      bus.start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (cyc != 34) begin failures++; $display("FAIL ignore_latency got=%0d exp=34", cyc); end
      checks++; if (bus.Q !== e[2*N-1:N]) begin failures++; $display("FAIL ignore_q got=%h exp=%h", bus.Q, e[2*N-1:N]); end
      checks++; if (bus.R !== e[N-1:0]) begin failures++; $display("FAIL ignore_r got=%h exp=%h", bus.R, e[N-1:0]); end
      // A start seen in DONE must be dropped as well.
      bus.start = 1'b1;
      bus.A     = 32'd55;
      bus.B     = 32'd0;
      stray     = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         bus.start = 1'b0;
         if (bus.done !== 1'b0 || bus.busy !== 1'b0) stray++;
      end
      checks++; if (stray != 0) begin failures++; $display("FAIL ignore_stray got=%0d exp=0", stray); end
      checks++; if (bus.Q !== e[2*N-1:N] || bus.R !== e[N-1:0]) begin
         failures++; $display("FAIL ignore_hold got=%h/%h exp=%h/%h", bus.Q, bus.R, e[2*N-1:N], e[N-1:0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [2*N:0] e;
      int cyc;
      issue(32'd5000, 32'd7, 1'b0);
      repeat (9) @(negedge clk);          // now in cycle 10
      rst       = 1'b1;
      bus.start = 1'b1;
      bus.B     = 32'd0;
      e = exp_q.pop_back();               // abandoned division
      @(negedge clk);                     // cycle 11
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rstmid_done got=%b exp=0", bus.done); end
      checks++; if (bus.Q !== '0 || bus.R !== '0) begin failures++; $display("FAIL rstmid_qr got=%h/%h exp=0/0", bus.Q, bus.R); end
      rst       = 1'b0;
      bus.start = 1'b0;
      issue(32'd5000, 32'd7, 1'b0);       // start in cycle 12
      wait_done(cyc);
      e = exp_q.pop_front();
      checks++; if (cyc != N + 2) begin failures++; $display("FAIL rstmid_latency got=%0d exp=%0d", cyc, N + 2); end
      checks++; if (bus.Q !== e[2*N-1:N]) begin failures++; $display("FAIL rstmid_q got=%h exp=%h", bus.Q, e[2*N-1:N]); end
      checks++; if (bus.R !== e[N-1:0]) begin failures++; $display("FAIL rstmid_r got=%h exp=%h", bus.R, e[N-1:0]); end
   endtask

   task automatic test_back_to_back();
      logic [2*N:0] e;
      logic [N-1:0] a, b;
      logic sop;
      int cyc;
      for (int i = 0; i < 12; i++) begin
         a   = $urandom();
         sop = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 3))
            0:       b = 32'($urandom_range(1, 300));
            1:       b = 32'd0;
            2:       b = 32'hFFFF_FFFF;
            default: b = $urandom();
         endcase
         issue(a, b, sop);
         wait_done(cyc);
         e = exp_q.pop_front();
         checks++; if (cyc != exp_lat(b)) begin failures++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", i, cyc, exp_lat(b)); end
         checks++; if (bus.Q !== e[2*N-1:N] || bus.R !== e[N-1:0] || bus.DZ !== e[2*N]) begin
            failures++;
            $display("FAIL b2b%0d_result got=%h/%h/%b exp=%h/%h/%b a=%h b=%h s=%b",
                     i, bus.Q, bus.R, bus.DZ, e[2*N-1:N], e[N-1:0], e[2*N], a, b, sop);
         end
      end
   endtask

   initial begin
      bus.start     = 1'b0;
      bus.signed_op = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      test_reset();
      test_unsigned();
      test_signed();
      test_div_zero();
      test_ignore_start();
      test_reset_mid();
      test_back_to_back();
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand/result width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signed_op  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A  input  N  dividend; sampled with start.
REQ-007 SHALL have port B  input  N  divisor; sampled with start.
REQ-008 SHALL have port busy  output  1  high while a division is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse; Q/R/DZ valid this cycle.
REQ-010 SHALL have port Q  output  N  quotient.
REQ-011 SHALL have port R  output  N  remainder.
REQ-012 SHALL have port DZ  output  1  divide-by-zero flag for the last result.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; transitions: IDLE->CALC on start; CALC->FIX after N iterations; FIX->DONE; DONE->IDLE unconditionally.
REQ-014 SHALL, on accepted start (cycle 0), latch operands, take magnitudes |A|, |B| when signed_op=1, and clear the iteration counter.
REQ-015 SHALL perform one restoring step per CALC cycle: shift {P, dividend MSB} left, trial = P - |B| at N+1 bits; borrow=1 -> keep P, quotient bit 0; borrow=0 -> P = trial, quotient bit 1.
REQ-016 SHALL, in FIX, negate Q when signed_op=1 and sign(A)!=sign(B), and give R the sign of A when signed_op=1.
REQ-017 SHALL assert done in cycle N+2 after the start cycle, for exactly one cycle; busy high cycles 1..N+1.
REQ-018 SHALL hold Q, R, DZ stable from done until the next accepted start.
REQ-019 SHALL ignore start while busy or in DONE; no operand re-latch.
REQ-020 SHALL produce Q = 2^(N-1), R = 0 for signed -2^(N-1) / -1 (wrap, no flag).
REQ-021 SHALL use modulo-2^N arithmetic for all negations; no other exception outputs.

Reset
REQ-022 SHALL, with rst high at a clock edge, enter IDLE and drive busy=0, done=0, Q=0, R=0, DZ=0 in the following cycle.
REQ-023 SHALL abandon any division in progress when rst is asserted mid-operation; no done pulse for it.
REQ-024 SHALL have rst take priority over start in the same cycle.

Configuration
REQ-025 SHALL honour macro DIV_ZERO_DETECT_EN: when defined, B=0 at start goes IDLE->DONE directly, done in cycle 1, DZ=1, Q=all ones, R=A (unmodified).
REQ-026 SHALL, without DIV_ZERO_DETECT_EN, tie DZ to 0 and run B=0 through the normal N+2-cycle path, outputting whatever the algorithm and FIX produce.

Structure
REQ-027 SHALL take the state encoding (IDLE, CALC, FIX, DONE) and default width constant from shared package div_pkg.
REQ-028 SHALL instantiate one combinational sub-module div_step (N+1-bit trial subtract, borrow out, select new partial remainder and quotient bit).
REQ-029 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-030 SHALL test unsigned 100 / 7, start at cycle 0 -> done at cycle 34, Q=14, R=2, DZ=0.
REQ-031 SHALL test signed -7 / 2 -> Q=0xFFFFFFFD, R=0xFFFFFFFF.
REQ-032 SHALL test signed 0x80000000 / 0xFFFFFFFF -> Q=0x80000000, R=0.
REQ-033 SHALL test A=0x1234, B=0 with DIV_ZERO_DETECT_EN -> done at cycle 1, DZ=1, Q=0xFFFFFFFF, R=0x1234.
REQ-034 SHALL test start pulses at cycles 5 and 20 during a busy division -> ignored, first result unchanged, done only at cycle 34.
REQ-035 SHALL test rst at cycle 10 of a division -> busy=0, Q=R=0 at cycle 11, no done; new start at cycle 12 completes normally.
